// File: rtl/baud_tick_gen.sv
// ============================================================================
// baud_tick_gen
// ----------------------------------------------------------------------------
// Baud timing engine for the UART. A 4-bit baud code selects a set of cycle
// divisors that are computed from CLK_FREQ at elaboration time. Two counters
// then produce the strobes used by the TX and RX datapaths:
//   - bit counter    : BIT_TICK once per bit period, MID_TICK at the half-bit
//                      point.
//   - sample counter : SAMPLE_TICK every DIV_SMP cycles. It is realigned to
//                      the bit boundary on every bit wrap, so rounding error
//                      never accumulates across bits.
// Any baud change or a RESYNC pulse restarts both counters from zero. RESYNC
// lets the receiver align the bit phase to a detected start-bit edge.
//
// Ports
//   clk          in   1      system clock, rising edge
//   reset        in   1      asynchronous, active-low reset
//   EN           in   1      1 = counters run; 0 = counters held at 0, no ticks
//   BAUD         in   4      baud code 0..11 (300 .. 921600); 12..15 invalid
//   RESYNC       in   1      1-cycle pulse: restart bit/sample phase
//   BIT_TICK     out  1      1-cycle strobe, period DIV_BIT cycles
//   MID_TICK     out  1      1-cycle strobe at the half-bit point
//   SAMPLE_TICK  out  1      1-cycle strobe, period DIV_SMP, realigned per bit
//   COUNT        out  CNT_W  active DIV_BIT (cycles per bit)
//   BAUD_ERR     out  1      1 = unsupported code, 300 baud substituted
// ============================================================================
module baud_tick_gen #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int OVERSAMPLE = 16,
  parameter int CNT_W      = 19
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             EN,
  input  logic [3:0]       BAUD,
  input  logic             RESYNC,
  output logic             BIT_TICK,
  output logic             MID_TICK,
  output logic             SAMPLE_TICK,
  output logic [CNT_W-1:0] COUNT,
  output logic             BAUD_ERR
);

  // --------------------------------------------------------------------------
  // Elaboration-time divisor calculation
  // --------------------------------------------------------------------------
  // Unsupported codes fall back to 300 baud so the line still has a sane,
  // slow timing while BAUD_ERR flags the problem.
  function automatic longint baud_rate(input int code);
    case (code)
      0:       return 300;
      1:       return 1200;
      2:       return 2400;
      3:       return 4800;
      4:       return 9600;
      5:       return 19200;
      6:       return 38400;
      7:       return 57600;
      8:       return 115200;
      9:       return 230400;
      10:      return 460800;
      11:      return 921600;
      default: return 300;
    endcase
  endfunction

  // Cycles per bit, rounded to nearest.
  function automatic longint calc_div_bit(input int code);
    longint rate;
    rate = baud_rate(code);
    return (longint'(CLK_FREQ) + rate / 2) / rate;
  endfunction

  // Cycles per oversample period, rounded to nearest and never below 1 so
  // the sample counter always has a legal wrap point.
  function automatic longint calc_div_smp(input int code);
    longint rate;
    longint div;
    rate = baud_rate(code) * longint'(OVERSAMPLE);
    div  = (longint'(CLK_FREQ) + rate / 2) / rate;
    return (div < 1) ? 1 : div;
  endfunction

  localparam logic [CNT_W-1:0] RST_COUNT = CNT_W'(calc_div_bit(0));

  // Constant lookup tables indexed by the registered baud code. Every entry
  // is a constant expression, so these reduce to fixed values in hardware.
  logic [CNT_W-1:0] div_bit_rom [16];
  logic [CNT_W-1:0] div_mid_rom [16];
  logic [CNT_W-1:0] div_smp_rom [16];

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_div_rom
      assign div_bit_rom[gi] = CNT_W'(calc_div_bit(gi));
      assign div_mid_rom[gi] = CNT_W'(calc_div_bit(gi) / 2);
      assign div_smp_rom[gi] = CNT_W'(calc_div_smp(gi));
    end
  endgenerate

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [3:0]       baud_q,     baud_d;
  logic [CNT_W-1:0] bit_cnt_q,  bit_cnt_d;
  logic [CNT_W-1:0] smp_cnt_q,  smp_cnt_d;
  logic             bit_tick_q, bit_tick_d;
  logic             mid_tick_q, mid_tick_d;
  logic             smp_tick_q, smp_tick_d;
  logic [CNT_W-1:0] count_q,    count_d;
  logic             baud_err_q, baud_err_d;

  // Divisors for the currently registered baud code.
  logic [CNT_W-1:0] div_bit_cur;
  logic [CNT_W-1:0] div_mid_cur;
  logic [CNT_W-1:0] div_smp_cur;

  assign div_bit_cur = div_bit_rom[baud_q];
  assign div_mid_cur = div_mid_rom[baud_q];
  assign div_smp_cur = div_smp_rom[baud_q];

  // Wrap detection uses >= so a counter can never run past its divisor,
  // even if it were left above a freshly selected, smaller divisor.
  logic bit_wrap;
  logic smp_wrap;
  logic restart;

  assign bit_wrap = (bit_cnt_q >= div_bit_cur - CNT_W'(1));
  assign smp_wrap = (smp_cnt_q >= div_smp_cur - CNT_W'(1));

  // A baud change is seen one edge before baud_q takes the new code, so the
  // restart and the switch to the new divisors land on the same edge.
  assign restart  = (BAUD != baud_q) || RESYNC;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    baud_d     = BAUD;
    count_d    = div_bit_cur;
    baud_err_d = (baud_q > 4'd11);

    // Counters idle at zero and ticks stay low unless counting normally;
    // this covers EN low as well as a restart from a baud change or RESYNC.
    bit_cnt_d  = '0;
    smp_cnt_d  = '0;
    bit_tick_d = 1'b0;
    mid_tick_d = 1'b0;
    smp_tick_d = 1'b0;

    if (EN && !restart) begin
      bit_cnt_d  = bit_wrap ? '0 : bit_cnt_q + CNT_W'(1);
      // The bit wrap realigns the sample phase to the new bit boundary.
      smp_cnt_d  = (bit_wrap || smp_wrap) ? '0 : smp_cnt_q + CNT_W'(1);
      bit_tick_d = bit_wrap;
      mid_tick_d = (bit_cnt_q == div_mid_cur - CNT_W'(1));
      smp_tick_d = bit_wrap || smp_wrap;
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      baud_q     <= 4'd0;
      bit_cnt_q  <= '0;
      smp_cnt_q  <= '0;
      bit_tick_q <= 1'b0;
      mid_tick_q <= 1'b0;
      smp_tick_q <= 1'b0;
      count_q    <= RST_COUNT;
      baud_err_q <= 1'b0;
    end else begin
      baud_q     <= baud_d;
      bit_cnt_q  <= bit_cnt_d;
      smp_cnt_q  <= smp_cnt_d;
      bit_tick_q <= bit_tick_d;
      mid_tick_q <= mid_tick_d;
      smp_tick_q <= smp_tick_d;
      count_q    <= count_d;
      baud_err_q <= baud_err_d;
    end
  end

  assign BIT_TICK    = bit_tick_q;
  assign MID_TICK    = mid_tick_q;
  assign SAMPLE_TICK = smp_tick_q;
  assign COUNT       = count_q;
  assign BAUD_ERR    = baud_err_q;

endmodule
